// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and data-memory handshake control for the 5-stage RV32 pipeline.
// Define PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic [4:0]  rs1_ex,
  input  logic [4:0]  rs2_ex,
  input  logic [4:0]  rd_ex,
  input  logic [4:0]  rd_mem,
  input  logic [4:0]  rd_wb,
  input  logic        reg_write_ex,
  input  logic        reg_write_mem,
  input  logic        reg_write_wb,
  input  logic        mem_read_ex,
  input  logic        jump_ex,
  input  logic        mem_access_mem,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_err,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        hold_exmem,
  output logic        flush_memwb,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {RUN = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);
  localparam logic [TIMEOUT_W-1:0] CNT_ZERO = TIMEOUT_W'(0);

  state_t               state_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 dmem_req_q;
  logic                 dmem_err_q;
  logic                 mem_hold_s;
  logic                 load_use_s;
  logic [5:0]           ctrl_s;

  // Forwarding select for one EX operand; the MEM stage holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_mem,
    input logic [4:0] rd_m,
    input logic       wr_wb,
    input logic [4:0] rd_w
  );
    if (wr_mem && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b01;
    end else if (wr_wb && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b10;
    end else begin
      return 2'b00;
    end
  endfunction

  // Data-memory handshake FSM with timeout; req/err are registered here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= RUN;
      cnt_q      <= CNT_ZERO;
      dmem_req_q <= 1'b0;
      dmem_err_q <= 1'b0;
    end else begin
      dmem_err_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (mem_access_mem) begin
            state_q    <= WAIT;
            dmem_req_q <= 1'b1;
            cnt_q      <= CNT_ZERO;
          end else begin
            dmem_req_q <= 1'b0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (dmem_ack) begin
            state_q    <= DONE;
            dmem_req_q <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= DONE;
            dmem_req_q <= 1'b0;
            dmem_err_q <= 1'b1;
          end else begin
            dmem_req_q <= 1'b1;
          end
        end
        DONE: begin
          state_q    <= RUN;
          dmem_req_q <= 1'b0;
        end
        default: begin
          state_q    <= RUN;
          dmem_req_q <= 1'b0;
        end
      endcase
    end
  end

  // Stall/flush arbitration: memory hold beats a taken jump beats load-use.
  always_comb begin
    mem_hold_s = ((state_q == RUN) && mem_access_mem) || (state_q == WAIT);
    load_use_s = mem_read_ex && (rd_ex != 5'd0) && ((rd_ex == rs1_id) || (rd_ex == rs2_id));
    // {stall_pc, stall_ifid, flush_ifid, flush_idex, hold_exmem, flush_memwb}
    ctrl_s = 6'b000000;
    if (!rstn) begin
      ctrl_s = 6'b000000;
    end else if (mem_hold_s) begin
      ctrl_s = 6'b110011;
    end else if (jump_ex) begin
      ctrl_s = 6'b001100;
    end else if (load_use_s) begin
      ctrl_s = 6'b110100;
    end else begin
      ctrl_s = 6'b000000;
    end
  end

  assign stall_pc    = ctrl_s[5];
  assign stall_ifid  = ctrl_s[4];
  assign flush_ifid  = ctrl_s[3];
  assign flush_idex  = ctrl_s[2];
  assign hold_exmem  = ctrl_s[1];
  assign flush_memwb = ctrl_s[0];
  assign dmem_req    = dmem_req_q;
  assign dmem_err    = dmem_err_q;

  assign fwd_a_sel = rstn ? fwd_sel(rs1_ex, reg_write_mem, rd_mem, reg_write_wb, rd_wb) : 2'b00;
  assign fwd_b_sel = rstn ? fwd_sel(rs2_ex, reg_write_mem, rd_mem, reg_write_wb, rd_wb) : 2'b00;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating next-count for both performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((stall_pc || hold_exmem) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_ifid && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

  // EX-stage write enable does not affect hazards handled here.
  logic unused_s;
  assign unused_s = reg_write_ex;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized run
// compared against a transaction-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic        reg_write_ex, reg_write_mem, reg_write_wb;
  logic        mem_read_ex, jump_ex, mem_access_mem, dmem_ack;
  logic        dmem_req, dmem_err;
  logic        stall_pc, stall_ifid, flush_ifid, flush_idex, hold_exmem, flush_memwb;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cycles, flush_count;
  logic [5:0]  hz;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign hz = {stall_pc, stall_ifid, flush_ifid, flush_idex, hold_exmem, flush_memwb};

  pipe_hazard_ctrl #(.TIMEOUT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
    .mem_read_ex(mem_read_ex), .jump_ex(jump_ex), .mem_access_mem(mem_access_mem),
    .dmem_ack(dmem_ack), .dmem_req(dmem_req), .dmem_err(dmem_err),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .hold_exmem(hold_exmem), .flush_memwb(flush_memwb),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic idle();
    rstn = 1'b1;
    rs1_id = 5'd0; rs2_id = 5'd0; rs1_ex = 5'd0; rs2_ex = 5'd0;
    rd_ex = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0;
    reg_write_ex = 1'b0; reg_write_mem = 1'b0; reg_write_wb = 1'b0;
    mem_read_ex = 1'b0; jump_ex = 1'b0; mem_access_mem = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    mem_access_mem = 1'b1; jump_ex = 1'b1;
    reg_write_mem = 1'b1; rd_mem = 5'd3; rs1_ex = 5'd3; rs2_ex = 5'd3;
    @(negedge clk);
    n_tests++;
    if (hz !== 6'b000000 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_outputs: got hz=%b fa=%b fb=%b want all 0", hz, fwd_a_sel, fwd_b_sel);
    end
    step();
    n_tests++;
    if (dmem_req !== 1'b0 || dmem_err !== 1'b0 || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got req=%b err=%b sc=%0d fc=%0d want 0", dmem_req, dmem_err, stall_cycles, flush_count);
    end
    idle();
    step();
  endtask

  task automatic test_load_use();
    idle();
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs2_id = 5'd5; rs1_id = 5'd1;
    @(negedge clk);
    n_tests++;
    if (hz !== 6'b110100) begin
      n_fail++;
      $display("FAIL load_use_stall: got %b want %b", hz, 6'b110100);
    end
    step();
    mem_read_ex = 1'b0; rd_ex = 5'd0; rd_mem = 5'd5; reg_write_mem = 1'b1;
    @(negedge clk);
    n_tests++;
    if (hz !== 6'b000000) begin
      n_fail++;
      $display("FAIL load_use_release: got %b want %b", hz, 6'b000000);
    end
    step();
    idle();
    mem_read_ex = 1'b1; rd_ex = 5'd0;
    @(negedge clk);
    n_tests++;
    if (hz !== 6'b000000) begin
      n_fail++;
      $display("FAIL load_use_x0: got %b want %b", hz, 6'b000000);
    end
    step();
    idle();
  endtask

  task automatic test_forwarding();
    idle();
    reg_write_mem = 1'b1; rd_mem = 5'd7; reg_write_wb = 1'b1; rd_wb = 5'd7;
    rs1_ex = 5'd7; rs2_ex = 5'd7;
    @(negedge clk);
    n_tests++;
    if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_mem_prio: got a=%b b=%b want 01", fwd_a_sel, fwd_b_sel);
    end
    reg_write_mem = 1'b0;
    @(negedge clk);
    n_tests++;
    if (fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_wb: got a=%b b=%b want 10", fwd_a_sel, fwd_b_sel);
    end
    reg_write_mem = 1'b1; rd_mem = 5'd0; rd_wb = 5'd0; rs1_ex = 5'd0; rs2_ex = 5'd9;
    @(negedge clk);
    n_tests++;
    if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_none_x0: got a=%b b=%b want 00", fwd_a_sel, fwd_b_sel);
    end
    step();
    idle();
  endtask

  task automatic test_mem_handshake();
    logic exp_req, exp_hold;
    idle();
    for (int c = 0; c < 6; c++) begin
      dmem_ack = (c == 3);
      mem_access_mem = (c <= 4);
      @(negedge clk);
      exp_req  = (c >= 1 && c <= 3);
      exp_hold = (c <= 3);
      n_tests++;
      if (dmem_req !== exp_req || hold_exmem !== exp_hold || flush_memwb !== exp_hold ||
          stall_pc !== exp_hold || dmem_err !== 1'b0) begin
        n_fail++;
        $display("FAIL handshake_c%0d: got req=%b hold=%b fmw=%b spc=%b err=%b want req=%b hold=%b err=0",
                 c, dmem_req, hold_exmem, flush_memwb, stall_pc, dmem_err, exp_req, exp_hold);
      end
      step();
    end
    idle();
  endtask

  task automatic test_priority();
    idle();
    mem_read_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; jump_ex = 1'b1;
    @(negedge clk);
    n_tests++;
    if (hz !== 6'b001100) begin
      n_fail++;
      $display("FAIL prio_jump_over_lu: got %b want %b", hz, 6'b001100);
    end
    mem_access_mem = 1'b1;
    @(negedge clk);
    n_tests++;
    if (hz !== 6'b110011) begin
      n_fail++;
      $display("FAIL prio_hold_over_all: got %b want %b", hz, 6'b110011);
    end
    step();
    mem_access_mem = 1'b0; dmem_ack = 1'b1;
    step();
    idle();
    step();
  endtask

  task automatic test_timeout();
    logic exp_req, exp_err;
    idle();
    for (int c = 0; c < 7; c++) begin
      mem_access_mem = (c == 0);
      @(negedge clk);
      exp_req = (c >= 1 && c <= 4);
      exp_err = (c == 5);
      n_tests++;
      if (dmem_req !== exp_req || dmem_err !== exp_err || hold_exmem !== (c <= 4)) begin
        n_fail++;
        $display("FAIL timeout_c%0d: got req=%b err=%b hold=%b want req=%b err=%b",
                 c, dmem_req, dmem_err, hold_exmem, exp_req, exp_err);
      end
      step();
    end
    for (int c = 0; c < 6; c++) begin
      mem_access_mem = (c == 0);
      dmem_ack = (c == 4);
      @(negedge clk);
      exp_req = (c >= 1 && c <= 4);
      n_tests++;
      if (dmem_req !== exp_req || dmem_err !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_at_limit_c%0d: got req=%b err=%b want req=%b err=0", c, dmem_req, dmem_err, exp_req);
      end
      step();
    end
    idle();
  endtask

  task automatic test_reset_in_wait();
    idle();
    mem_access_mem = 1'b1;
    step();
    mem_access_mem = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dmem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait_pre: got req=%b want 1", dmem_req);
    end
    step();
    rstn = 1'b0; jump_ex = 1'b1; reg_write_wb = 1'b1; rd_wb = 5'd4; rs1_ex = 5'd4;
    @(negedge clk);
    n_tests++;
    if (hz !== 6'b000000 || fwd_a_sel !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_wait_forced: got hz=%b fa=%b want 0", hz, fwd_a_sel);
    end
    step();
    idle();
    @(negedge clk);
    n_tests++;
    if (dmem_req !== 1'b0 || dmem_err !== 1'b0 || hz !== 6'b000000 ||
        stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_wait_post: got req=%b err=%b hz=%b sc=%0d fc=%0d want 0",
               dmem_req, dmem_err, hz, stall_cycles, flush_count);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (dmem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_no_err: got err=%b want 0", dmem_err);
    end
    step();
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (!rstn || rs == 5'd0) return 2'b00;
    if (reg_write_mem && rd_mem == rs) return 2'b01;
    if (reg_write_wb && rd_wb == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_random();
    bit      m_busy, m_release, m_err;
    int      m_waited;
    longint  m_stall, m_flush;
    logic [5:0] exp_hz;
    logic    hold, lu;
    longint  exp_sc, exp_fc;
    m_busy = 1'b0; m_release = 1'b0; m_err = 1'b0; m_waited = 0; m_stall = 0; m_flush = 0;
    idle();
    rstn = 1'b0;
    step();
    for (int i = 0; i < 500; i++) begin
      rstn = ($urandom_range(0, 59) != 0);
      rs1_id = 5'($urandom_range(0, 3)); rs2_id = 5'($urandom_range(0, 3));
      rs1_ex = 5'($urandom_range(0, 3)); rs2_ex = 5'($urandom_range(0, 3));
      rd_ex = 5'($urandom_range(0, 3)); rd_mem = 5'($urandom_range(0, 3)); rd_wb = 5'($urandom_range(0, 3));
      reg_write_ex = 1'($urandom_range(0, 1));
      reg_write_mem = 1'($urandom_range(0, 1)); reg_write_wb = 1'($urandom_range(0, 1));
      mem_read_ex = 1'($urandom_range(0, 1));
      jump_ex = ($urandom_range(0, 4) == 0);
      mem_access_mem = ($urandom_range(0, 3) == 0);
      dmem_ack = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      hold = m_busy || (!m_release && mem_access_mem);
      lu = mem_read_ex && rd_ex != 5'd0 && (rd_ex == rs1_id || rd_ex == rs2_id);
      if (!rstn) exp_hz = 6'b000000;
      else if (hold) exp_hz = 6'b110011;
      else if (jump_ex) exp_hz = 6'b001100;
      else if (lu) exp_hz = 6'b110100;
      else exp_hz = 6'b000000;
`ifdef PERF_CNT_EN
      exp_sc = m_stall; exp_fc = m_flush;
`else
      exp_sc = 0; exp_fc = 0;
`endif
      n_tests++;
      if (hz !== exp_hz || fwd_a_sel !== fwd_ref(rs1_ex) || fwd_b_sel !== fwd_ref(rs2_ex) ||
          dmem_req !== m_busy || dmem_err !== m_err ||
          stall_cycles !== 32'(exp_sc) || flush_count !== 32'(exp_fc)) begin
        n_fail++;
        $display("FAIL random_%0d: got hz=%b fa=%b fb=%b req=%b err=%b sc=%0d fc=%0d want hz=%b fa=%b fb=%b req=%b err=%b sc=%0d fc=%0d",
                 i, hz, fwd_a_sel, fwd_b_sel, dmem_req, dmem_err, stall_cycles, flush_count,
                 exp_hz, fwd_ref(rs1_ex), fwd_ref(rs2_ex), m_busy, m_err, exp_sc, exp_fc);
      end
      if (!rstn) begin
        m_busy = 1'b0; m_release = 1'b0; m_err = 1'b0; m_waited = 0; m_stall = 0; m_flush = 0;
      end else begin
        if ((exp_hz[5] || exp_hz[1]) && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (exp_hz[3] && m_flush < 64'hFFFF_FFFF) m_flush++;
        m_err = 1'b0;
        if (m_busy) begin
          m_waited++;
          if (dmem_ack || m_waited == TO) begin
            m_err = !dmem_ack;
            m_busy = 1'b0;
            m_release = 1'b1;
          end
        end else if (m_release) begin
          m_release = 1'b0;
        end else if (mem_access_mem) begin
          m_busy = 1'b1;
          m_waited = 0;
        end
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    test_reset();
    test_load_use();
    test_forwarding();
    test_mem_handshake();
    test_priority();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
